// File: rtl/mpc_mul_share_arb_if.sv
// Requester and multiplier bus of the shared MPC multiplier scheduler.
// The scheduler connects through the slave modport; requesters and the multiplier connect through master.
interface mpc_mul_share_arb_if #(
    parameter int NREQ = 4,
    parameter int AW   = 21,
    parameter int BW   = 6,
    parameter int PW   = 28
) ();
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_a;
    logic [NREQ*BW-1:0] req_b;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    rsp_valid;
    logic [PW-1:0]      rsp_p;
    logic               mul_ce;
    logic [AW-1:0]      mul_a;
    logic [BW-1:0]      mul_b;
    logic [PW-1:0]      mul_p;

    modport master (
        output req_valid, req_a, req_b, mul_p,
        input  req_ready, rsp_valid, rsp_p, mul_ce, mul_a, mul_b
    );

    modport slave (
        input  req_valid, req_a, req_b, mul_p,
        output req_ready, rsp_valid, rsp_p, mul_ce, mul_a, mul_b
    );
endinterface

// File: rtl/mpc_mul_share_arb.sv
// Round-robin sharing of one pipelined signed x unsigned multiplier among NREQ requesters.
// A tag pipeline moves in lock-step with the multiplier ce so each product returns to its issuer.
module mpc_mul_share_arb #(
    parameter int NREQ = 4,
    parameter int AW   = 21,
    parameter int BW   = 6,
    parameter int PW   = 28,
    parameter int LAT  = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                hold,
    output logic                busy,
    mpc_mul_share_arb_if.slave  bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IW-1:0] last_grant;
    logic [IW-1:0] grant_idx;
    logic [IW-1:0] cand;
    logic          grant_any;
    logic          ce;
    logic [LAT-1:0] tag_v;
    logic [IW-1:0]  tag_idx [LAT];

    // Reset forces ce high so the multiplier is never left frozen by a stale hold.
    assign ce         = ~hold | ~rst;
    assign bus.mul_ce = ce;

    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IW'((int'(last_grant) + k) % NREQ);
            if (!grant_any && bus.req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
        if (hold || !rst) begin
            grant_any = 1'b0;
        end
    end

    // Idle cycles feed zero operands; their tags are invalid so the product is never reported.
    always_comb begin
        bus.mul_a     = '0;
        bus.mul_b     = '0;
        bus.req_ready = '0;
        if (grant_any) begin
            bus.mul_a              = bus.req_a[int'(grant_idx)*AW +: AW];
            bus.mul_b              = bus.req_b[int'(grant_idx)*BW +: BW];
            bus.req_ready[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= '0;
            tag_v      <= '0;
            for (int i = 0; i < LAT; i++) begin
                tag_idx[i] <= '0;
            end
        end else begin
            if (grant_any) begin
                last_grant <= grant_idx;
            end
            if (ce) begin
                tag_v[0]   <= grant_any;
                tag_idx[0] <= grant_idx;
                for (int i = 1; i < LAT; i++) begin
                    tag_v[i]   <= tag_v[i-1];
                    tag_idx[i] <= tag_idx[i-1];
                end
            end
        end
    end

    // A result leaving the last stage during hold is frozen and strobed once hold drops.
    always_comb begin
        bus.rsp_valid = '0;
        if (tag_v[LAT-1] && !hold) begin
            bus.rsp_valid[tag_idx[LAT-1]] = 1'b1;
        end
    end

    assign bus.rsp_p = bus.mul_p;
    assign busy      = |tag_v;
endmodule

// File: tb/tb_mpc_mul_share_arb.sv
// Scoreboard bench for mpc_mul_share_arb with a ce-gated three-stage multiplier model.
// Directed vectors push hand-computed responses; a negedge monitor pops and compares them.
module tb_mpc_mul_share_arb;
    localparam int NREQ = 4;
    localparam int AW   = 21;
    localparam int BW   = 6;
    localparam int PW   = 28;
    localparam int LAT  = 3;

    typedef struct {
        logic [NREQ-1:0]        oneHot;
        logic signed [PW-1:0]   p;
        int                     due;
    } exp_t;

    logic clk;
    logic rst;
    logic hold;
    logic busy;
    logic [NREQ-1:0]      reqValid;
    logic signed [AW-1:0] opA [NREQ];
    logic [BW-1:0]        opB [NREQ];
    logic signed [PW-1:0] p1, p2, p3;

    exp_t sbQueue [$];
    exp_t e;
    int   ceCount;
    int   testCount;
    int   failCount;

    mpc_mul_share_arb_if #(.NREQ(NREQ), .AW(AW), .BW(BW), .PW(PW)) ifc ();

    mpc_mul_share_arb #(.NREQ(NREQ), .AW(AW), .BW(BW), .PW(PW), .LAT(LAT)) dut (
        .clk  (clk),
        .rst  (rst),
        .hold (hold),
        .busy (busy),
        .bus  (ifc.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_comb begin
        ifc.req_a     = '0;
        ifc.req_b     = '0;
        ifc.req_valid = reqValid;
        for (int i = 0; i < NREQ; i++) begin
            ifc.req_a[i*AW +: AW] = opA[i];
            ifc.req_b[i*BW +: BW] = opB[i];
        end
    end

    // Multiplier model: signed A times zero-extended B, three ce-gated register stages.
    always @(posedge clk) begin
        if (ifc.mul_ce) begin
            p1 <= PW'($signed(ifc.mul_a)) * PW'($signed({1'b0, ifc.mul_b}));
            p2 <= p1;
            p3 <= p2;
        end
    end
    assign ifc.mul_p = p3;

    always @(posedge clk) begin
        if (rst && !hold) begin
            ceCount <= ceCount + 1;
        end
    end

    task automatic checkOutput(input string name, input longint act, input longint expv);
        testCount++;
        if (act !== expv) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] v, input logic h,
                                 input logic [NREQ-1:0] expReady,
                                 input logic signed [PW-1:0] expP, input int expBusy);
        exp_t item;
        reqValid = v;
        hold     = h;
        @(negedge clk);
        checkOutput("req_ready", longint'(ifc.req_ready), longint'(expReady));
        if (expBusy >= 0) begin
            checkOutput("busy", longint'(busy), longint'(expBusy));
        end
        if (expReady != '0) begin
            item.oneHot = expReady;
            item.p      = expP;
            item.due    = ceCount + LAT;
            sbQueue.push_back(item);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic doReset(input logic holdDuring);
        rst      = 1'b0;
        hold     = holdDuring;
        reqValid = '1;
        sbQueue.delete();
        @(negedge clk);
        checkOutput("rst_req_ready", longint'(ifc.req_ready), 0);
        checkOutput("rst_rsp_valid", longint'(ifc.rsp_valid), 0);
        checkOutput("rst_busy", longint'(busy), 0);
        checkOutput("rst_mul_a", longint'(ifc.mul_a), 0);
        checkOutput("rst_mul_b", longint'(ifc.mul_b), 0);
        checkOutput("rst_mul_ce", longint'(ifc.mul_ce), 1);
        @(posedge clk);
        #1;
        reqValid = '0;
        hold     = 1'b0;
        rst      = 1'b1;
    endtask

    // Monitor: every strobe must match the oldest expected response, at its due ce count.
    always @(negedge clk) begin
        if (rst) begin
            if (hold) begin
                checkOutput("rsp_valid_hold", longint'(ifc.rsp_valid), 0);
            end else if (ifc.rsp_valid != '0) begin
                if (sbQueue.size() == 0) begin
                    testCount++;
                    failCount++;
                    $display("[TB] FAIL unexpected_rsp: got rsp_valid=%b expected none", ifc.rsp_valid);
                end else begin
                    e = sbQueue.pop_front();
                    checkOutput("rsp_valid", longint'(ifc.rsp_valid), longint'(e.oneHot));
                    checkOutput("rsp_p", longint'($signed(ifc.rsp_p)), longint'(e.p));
                    checkOutput("rsp_latency", longint'(ceCount), longint'(e.due));
                end
            end else if (sbQueue.size() != 0 && sbQueue[0].due <= ceCount) begin
                e = sbQueue.pop_front();
                testCount++;
                failCount++;
                $display("[TB] FAIL missing_rsp: got no rsp_valid expected %b p=%0d", e.oneHot, e.p);
            end
        end
    end

    initial begin
        testCount = 0;
        failCount = 0;
        ceCount   = 0;
        rst       = 1'b0;
        hold      = 1'b0;
        reqValid  = '0;
        for (int i = 0; i < NREQ; i++) begin
            opA[i] = '0;
            opB[i] = '0;
        end

        doReset(1'b1);

        // Single request from requester 2, with busy profile.
        opA[2] = AW'(-5);
        opB[2] = BW'(7);
        applyStimulus(4'b0100, 1'b0, 4'b0100, PW'(-35), 0);
        applyStimulus(4'b0000, 1'b0, 4'b0000, '0, 1);
        applyStimulus(4'b0000, 1'b0, 4'b0000, '0, 1);
        applyStimulus(4'b0000, 1'b0, 4'b0000, '0, 1);
        applyStimulus(4'b0000, 1'b0, 4'b0000, '0, 0);

        // All requesters valid from reset: grants rotate 1,2,3,0,1.
        doReset(1'b0);
        for (int i = 0; i < NREQ; i++) begin
            opA[i] = AW'(i + 1);
            opB[i] = BW'(10);
        end
        applyStimulus(4'b1111, 1'b0, 4'b0010, PW'(20), 0);
        applyStimulus(4'b1111, 1'b0, 4'b0100, PW'(30), 1);
        applyStimulus(4'b1111, 1'b0, 4'b1000, PW'(40), 1);
        applyStimulus(4'b1111, 1'b0, 4'b0001, PW'(10), 1);
        applyStimulus(4'b1111, 1'b0, 4'b0010, PW'(20), 1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(4'b0000, 1'b0, 4'b0000, '0, -1);
        end

        // Operand extremes; pointer is at 1 so requester 0 wins first.
        opA[0] = AW'(-1048576);
        opB[0] = BW'(63);
        opA[1] = AW'(1048575);
        opB[1] = BW'(63);
        applyStimulus(4'b0011, 1'b0, 4'b0001, PW'(-66060288), -1);
        applyStimulus(4'b0010, 1'b0, 4'b0010, PW'(66060225), -1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(4'b0000, 1'b0, 4'b0000, '0, -1);
        end

        // Two requests then two hold cycles; a request pending through hold is not accepted.
        opA[2] = AW'(3);
        opB[2] = BW'(4);
        opA[3] = AW'(-7);
        opB[3] = BW'(9);
        opA[0] = AW'(2);
        opB[0] = BW'(5);
        applyStimulus(4'b0100, 1'b0, 4'b0100, PW'(12), -1);
        applyStimulus(4'b1000, 1'b0, 4'b1000, PW'(-63), -1);
        applyStimulus(4'b0001, 1'b1, 4'b0000, '0, 1);
        applyStimulus(4'b0001, 1'b1, 4'b0000, '0, 1);
        applyStimulus(4'b0001, 1'b0, 4'b0001, PW'(10), 1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(4'b0000, 1'b0, 4'b0000, '0, -1);
        end

        // Reset while two results are in flight: both are discarded, pointer restarts.
        opA[1] = AW'(11);
        opB[1] = BW'(2);
        opA[2] = AW'(-13);
        opB[2] = BW'(3);
        applyStimulus(4'b0010, 1'b0, 4'b0010, PW'(22), -1);
        applyStimulus(4'b0100, 1'b0, 4'b0100, PW'(-39), -1);
        doReset(1'b0);
        opA[0] = AW'(6);
        opB[0] = BW'(6);
        opA[1] = AW'(-9);
        opB[1] = BW'(4);
        applyStimulus(4'b0011, 1'b0, 4'b0010, PW'(-36), 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(4'b0000, 1'b0, 4'b0000, '0, -1);
        end

        // Requester 0 alone: granted every cycle with no bubbles.
        opA[0] = AW'(100);
        opB[0] = BW'(1);
        applyStimulus(4'b0001, 1'b0, 4'b0001, PW'(100), -1);
        opA[0] = AW'(-100);
        opB[0] = BW'(2);
        applyStimulus(4'b0001, 1'b0, 4'b0001, PW'(-200), -1);
        opA[0] = AW'(0);
        opB[0] = BW'(3);
        applyStimulus(4'b0001, 1'b0, 4'b0001, PW'(0), -1);
        opA[0] = AW'(1048575);
        opB[0] = BW'(0);
        applyStimulus(4'b0001, 1'b0, 4'b0001, PW'(0), -1);
        opA[0] = AW'(-1);
        opB[0] = BW'(63);
        applyStimulus(4'b0001, 1'b0, 4'b0001, PW'(-63), 1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(4'b0000, 1'b0, 4'b0000, '0, -1);
        end

        checkOutput("queue_drained", longint'(sbQueue.size()), 0);
        checkOutput("final_busy", longint'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end
endmodule

// File: doc/mpc_mul_share_arb.md
# mpc_mul_share_arb

Round-robin scheduler that shares one pipelined signed×unsigned multiplier (21-bit signed × 6-bit unsigned → 28-bit signed, three ce-gated register stages) among NREQ requesters inside the MPC solver datapath. Each accepted request is tagged with its requester index. The tag travels down a shadow pipeline kept in lock-step with the multiplier's clock enable, so each product returns to the requester that issued it. The block also owns the multiplier's ce, so a global hold freezes operands, tags and products together.

## Interface
- NREQ, 4: number of requesters (2..8)
- AW, 21: operand A width, signed
- BW, 6: operand B width, unsigned
- PW, 28: product width, signed
- LAT, 3: ce-enabled clock edges from operands presented on mul_a/mul_b to the product valid on mul_p

- clk  in  1  single clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_a  in  NREQ*AW  packed operands A, requester i at [i*AW +: AW]
- req_b  in  NREQ*BW  packed operands B, requester i at [i*BW +: BW]
- req_ready  out  NREQ  one-hot grant; handshake completes when req_valid[i] & req_ready[i]
- hold  in  1  global stall from the solver sequencer
- mul_ce  out  1  multiplier clock enable
- mul_a  out  AW  operand A to multiplier
- mul_b  out  BW  operand B to multiplier
- mul_p  in  PW  product from multiplier
- rsp_valid  out  NREQ  one-hot result strobe
- rsp_p  out  PW  result, equal to mul_p
- busy  out  1  at least one product in flight

## Operation
- mul_ce = ~hold, combinational.
- Arbitration:
  - While hold=0, grant exactly one valid requester per cycle, round-robin.
  - Search starts at (last_grant+1) mod NREQ.
  - last_grant is a register, reset 0. Search therefore starts at index 1 after reset.
- Grant signals:
  - req_ready is combinational.
  - Zero while hold=1 or no requester is valid.
  - Never asserted for a requester whose req_valid=0.
- Operand mux:
  - mul_a/mul_b take the granted requester's operands.
  - With no grant they drive zero. A product computed from zero is never reported, because its tag is invalid.
- Tag pipeline:
  - LAT stages of {valid, idx[clog2(NREQ)-1:0]}.
  - Stage 0 loads {grant_any, grant_idx}. Higher stages shift.
  - Advances only when mul_ce=1. While hold=1 it holds, mirroring the multiplier registers.
- Response:
  - rsp_valid[idx] = tag[LAT-1].valid & ~hold.
  - rsp_p = mul_p.
  - Each result is strobed exactly once, on the cycle its tag leaves the last stage.
- busy = OR of all tag valid bits.
- Width rules:
  - Product = signed A × zero-extended B.
  - Full range is 21s×6u → 27 bits significant, sign-extended to 28. No truncation or saturation in this block.
- Reset, including mid-operation:
  - Clears all tag valid bits and last_grant. In-flight results are discarded with no rsp_valid.
  - mul_p content after reset is don't-care.
  - Outputs while rst=0: req_ready=0, rsp_valid=0, busy=0, mul_a=0, mul_b=0, mul_ce=1.

## Timing
- Grant latency: combinational, same cycle as req_valid (hold=0).
- Throughput: one product per cycle when not stalled.
- Result latency: a request accepted in cycle t with no hold produces rsp_valid in cycle t+LAT (t+3 by default).
- Each hold cycle adds exactly one cycle of latency to every in-flight result.
- hold asserted the same cycle as a pending request: request not accepted. The requester must keep req_valid and operands stable until req_ready.
- Simultaneous issue and retire in one cycle is normal. A pipeline of depth LAT is never full-blocking.
- rst deassertion is synchronized externally. The first grant can occur in the first cycle after rst rises.

## Test plan
- Single request, requester 2: a=-5, b=7, hold=0 in cycle 0 → req_ready=4'b0100 in cycle 0; rsp_valid=4'b0100, rsp_p=-35 in cycle 3; busy=1 in cycles 1–3, then 0.
- All four requesters valid continuously, from reset → grants 1,2,3,0,1 in consecutive cycles; responses return in the same order, each 3 cycles after its grant, with a=i+1, b=10 giving rsp_p=(i+1)*10.
- Extremes: a=-1048576, b=63 → rsp_p=-66060288. Also a=1048575, b=63 → 66060225.
- Requests at cycles 0 and 1, hold=1 in cycles 2–3:
  - first response in cycle 5, second in cycle 6;
  - no rsp_valid during the hold cycles;
  - req_ready=0 while hold=1.
- Issue two requests, then pulse rst low in the cycle after the second grant → no rsp_valid ever for either; busy=0 immediately; the next grant goes to index 1 if valid.
- Only requester 0 valid for 5 cycles → granted every cycle, five responses in order, with no bubbles introduced by the round-robin pointer.
